// File: rtl/shape_processor_modeling.sv
// Shape processor CTRL SFR model: field encodings, register packing and legality rules.
package shape_processor_modeling;

  typedef enum logic [2:0] {
    KEEP_SHAPE = 3'd0,
    CIRCLE     = 3'd1,
    RECTANGLE  = 3'd2,
    TRIANGLE   = 3'd3
  } shape_e;

  typedef enum logic [2:0] {
    KEEP_OPERATION = 3'd0,
    AREA           = 3'd1,
    PERIMETER      = 3'd2,
    IS_SQUARE      = 3'd3,
    IS_EQUILATERAL = 3'd4,
    IS_ISOSCELES   = 3'd5
  } operation_e;

  typedef struct packed {
    logic [25:0] rsvd;
    operation_e  operation;
    shape_e      shape;
  } ctrl_sfr_reg;

  function automatic logic is_reserved_shape(input shape_e s);
    return !(s inside {KEEP_SHAPE, CIRCLE, RECTANGLE, TRIANGLE});
  endfunction

  function automatic logic is_reserved_operation(input operation_e o);
    return !(o inside {KEEP_OPERATION, AREA, PERIMETER, IS_SQUARE, IS_EQUILATERAL, IS_ISOSCELES});
  endfunction

  // Concrete shape/operation pairs the processor will store; KEEP values are never legal here.
  function automatic logic is_legal_combination(input shape_e s, input operation_e o);
    logic legal;
    case (o)
      AREA, PERIMETER:              legal = s inside {CIRCLE, RECTANGLE, TRIANGLE};
      IS_SQUARE:                    legal = (s == RECTANGLE);
      IS_EQUILATERAL, IS_ISOSCELES: legal = (s == TRIANGLE);
      default:                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/shape_processor_ctrl_driver_if.sv
// Request/response handshake plus CTRL write/read port of the shape processor driver.
interface shape_processor_ctrl_driver_if;
  import shape_processor_modeling::*;

  logic        req_valid;
  logic        req_ready;
  shape_e      req_shape;
  operation_e  req_operation;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  shape_e      rsp_shape;
  operation_e  rsp_operation;

  logic                           write;
  logic [$bits(ctrl_sfr_reg)-1:0] write_data;
  logic                           read;
  logic [$bits(ctrl_sfr_reg)-1:0] read_data;

  modport master (
    input  req_valid, req_shape, req_operation, rsp_ready, read_data,
    output req_ready, rsp_valid, rsp_status, rsp_shape, rsp_operation,
           write, write_data, read
  );

  modport slave (
    output req_valid, req_shape, req_operation, rsp_ready, read_data,
    input  req_ready, rsp_valid, rsp_status, rsp_shape, rsp_operation,
           write, write_data, read
  );
endinterface

// File: rtl/shape_processor_ctrl_driver.sv
// CTRL SFR write/readback driver with shadow-based outcome prediction.
// Optional SHAPE_PROCESSOR_CTRL_DRIVER_PRECHECK_EN rejects predicted-illegal requests without bus traffic.
module shape_processor_ctrl_driver
  import shape_processor_modeling::*;
#(
  parameter int unsigned READ_LATENCY = 0
) (
  input logic                          clk,
  input logic                          rst,
  shape_processor_ctrl_driver_if.master bus
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LATENCY);

  localparam logic [1:0] ST_UPDATED  = 2'd0;
  localparam logic [1:0] ST_IGNORED  = 2'd1;
  localparam logic [1:0] ST_MISMATCH = 2'd2;
  localparam logic [1:0] ST_REJECT   = 2'd3;

`ifdef SHAPE_PROCESSOR_CTRL_DRIVER_PRECHECK_EN
  localparam bit PRECHECK_EN = 1'b1;
`else
  localparam bit PRECHECK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {INIT_RD, INIT_WAIT, IDLE, WR, RD, RD_WAIT, RSP} state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  shape_e      shadow_shape_q, shadow_shape_d;
  operation_e  shadow_op_q, shadow_op_d;
  shape_e      pred_shape_q, pred_shape_d;
  operation_e  pred_op_q, pred_op_d;
  logic        pred_legal_q, pred_legal_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  shape_e      rsp_shape_q, rsp_shape_d;
  operation_e  rsp_op_q, rsp_op_d;
  logic        write_q, write_d;
  ctrl_sfr_reg write_data_q, write_data_d;
  logic        read_q, read_d;

  shape_e      eff_shape_c;
  operation_e  eff_op_c;
  logic        legal_c;
  logic        rd_done_c;
  ctrl_sfr_reg readback_c;
  ctrl_sfr_reg pred_sfr_c;

  // KEEP fields resolve against the shadow before the legality check.
  assign eff_shape_c = (bus.req_shape == KEEP_SHAPE) ? shadow_shape_q : bus.req_shape;
  assign eff_op_c    = (bus.req_operation == KEEP_OPERATION) ? shadow_op_q : bus.req_operation;
  assign legal_c     = !is_reserved_shape(bus.req_shape) && !is_reserved_operation(bus.req_operation)
                       && is_legal_combination(eff_shape_c, eff_op_c);
  assign rd_done_c   = (cnt_q == LAT_LAST);
  assign readback_c  = ctrl_sfr_reg'(bus.read_data);
  assign pred_sfr_c  = '{rsvd: '0, operation: pred_op_q, shape: pred_shape_q};

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shadow_shape_d = shadow_shape_q;
    shadow_op_d    = shadow_op_q;
    pred_shape_d   = pred_shape_q;
    pred_op_d      = pred_op_q;
    pred_legal_d   = pred_legal_q;
    req_ready_d    = 1'b0;
    rsp_valid_d    = 1'b0;
    rsp_status_d   = rsp_status_q;
    rsp_shape_d    = rsp_shape_q;
    rsp_op_d       = rsp_op_q;
    write_d        = 1'b0;
    write_data_d   = write_data_q;
    read_d         = 1'b0;

    case (state_q)
      INIT_RD: begin
        read_d  = 1'b1;
        cnt_d   = '0;
        state_d = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (rd_done_c) begin
          shadow_shape_d = readback_c.shape;
          shadow_op_d    = readback_c.operation;
          req_ready_d    = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid) begin
          req_ready_d  = 1'b0;
          pred_legal_d = legal_c;
          pred_shape_d = legal_c ? eff_shape_c : shadow_shape_q;
          pred_op_d    = legal_c ? eff_op_c : shadow_op_q;
          if (PRECHECK_EN && !legal_c) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_REJECT;
            rsp_shape_d  = shadow_shape_q;
            rsp_op_d     = shadow_op_q;
            state_d      = RSP;
          end else begin
            write_d      = 1'b1;
            write_data_d = '{rsvd: '0, operation: bus.req_operation, shape: bus.req_shape};
            state_d      = WR;
          end
        end
      end
      WR: begin
        read_d  = 1'b1;
        cnt_d   = '0;
        state_d = RD;
      end
      RD, RD_WAIT: begin
        if (rd_done_c) begin
          rsp_valid_d    = 1'b1;
          rsp_status_d   = (readback_c != pred_sfr_c) ? ST_MISMATCH :
                           pred_legal_q ? ST_UPDATED : ST_IGNORED;
          rsp_shape_d    = readback_c.shape;
          rsp_op_d       = readback_c.operation;
          shadow_shape_d = readback_c.shape;
          shadow_op_d    = readback_c.operation;
          state_d        = RSP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = RD_WAIT;
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = INIT_RD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= INIT_RD;
      cnt_q          <= '0;
      shadow_shape_q <= KEEP_SHAPE;
      shadow_op_q    <= KEEP_OPERATION;
      pred_shape_q   <= KEEP_SHAPE;
      pred_op_q      <= KEEP_OPERATION;
      pred_legal_q   <= 1'b0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_status_q   <= ST_UPDATED;
      rsp_shape_q    <= KEEP_SHAPE;
      rsp_op_q       <= KEEP_OPERATION;
      write_q        <= 1'b0;
      write_data_q   <= '0;
      read_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_shape_q <= shadow_shape_d;
      shadow_op_q    <= shadow_op_d;
      pred_shape_q   <= pred_shape_d;
      pred_op_q      <= pred_op_d;
      pred_legal_q   <= pred_legal_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_status_q   <= rsp_status_d;
      rsp_shape_q    <= rsp_shape_d;
      rsp_op_q       <= rsp_op_d;
      write_q        <= write_d;
      write_data_q   <= write_data_d;
      read_q         <= read_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_status    = rsp_status_q;
  assign bus.rsp_shape     = rsp_shape_q;
  assign bus.rsp_operation = rsp_op_q;
  assign bus.write         = write_q;
  assign bus.write_data    = write_data_q;
  assign bus.read          = read_q;

endmodule

// File: tb/tb_shape_processor_ctrl_driver.sv
// Directed bench for shape_processor_ctrl_driver with READ_LATENCY 0 and 3 instances.
module tb_shape_processor_ctrl_driver;
  import shape_processor_modeling::*;

  localparam logic [31:0] GARB = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst0, rst3;
  logic [31:0] proc0, proc3;
  logic [2:0]  rd_pipe3 = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  shape_processor_ctrl_driver_if if0 ();
  shape_processor_ctrl_driver_if if3 ();

  shape_processor_ctrl_driver #(.READ_LATENCY(0)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  shape_processor_ctrl_driver #(.READ_LATENCY(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3));

  // Processor stand-ins: data only valid in the exact latency slot, all-ones otherwise.
  assign if0.read_data = if0.read ? proc0 : GARB;
  always @(posedge clk) rd_pipe3 <= {rd_pipe3[1:0], if3.read};
  assign if3.read_data = rd_pipe3[2] ? proc3 : GARB;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request on the latency-0 driver; status 3 means no bus traffic is expected.
  task automatic req0(input string tag, input shape_e s, input operation_e o,
                      input logic [31:0] wd, input logic [31:0] proc_after,
                      input logic [1:0] st, input shape_e rs, input operation_e ro);
    chk({tag, "/req_ready"}, 32'(if0.req_ready), 32'd1);
    if0.req_valid = 1'b1; if0.req_shape = s; if0.req_operation = o;
    @(negedge clk);
    if0.req_valid = 1'b0;
    if (st == 2'd3) begin
      chk({tag, "/write"}, 32'(if0.write), 32'd0);
      chk({tag, "/read"}, 32'(if0.read), 32'd0);
      chk({tag, "/rsp_valid"}, 32'(if0.rsp_valid), 32'd1);
    end else begin
      chk({tag, "/write"}, 32'(if0.write), 32'd1);
      chk({tag, "/write_data"}, if0.write_data, wd);
      chk({tag, "/rsp_valid_early"}, 32'(if0.rsp_valid), 32'd0);
      proc0 = proc_after;
      @(negedge clk);
      chk({tag, "/write_drop"}, 32'(if0.write), 32'd0);
      chk({tag, "/read"}, 32'(if0.read), 32'd1);
      @(negedge clk);
      chk({tag, "/read_drop"}, 32'(if0.read), 32'd0);
      chk({tag, "/rsp_valid"}, 32'(if0.rsp_valid), 32'd1);
    end
    chk({tag, "/status"}, 32'(if0.rsp_status), 32'(st));
    chk({tag, "/rsp_shape"}, 32'(if0.rsp_shape), 32'(rs));
    chk({tag, "/rsp_op"}, 32'(if0.rsp_operation), 32'(ro));
    chk({tag, "/busy"}, 32'(if0.req_ready), 32'd0);
    if0.rsp_ready = 1'b1;
    @(negedge clk);
    if0.rsp_ready = 1'b0;
    chk({tag, "/rsp_drop"}, 32'(if0.rsp_valid), 32'd0);
    chk({tag, "/ready_back"}, 32'(if0.req_ready), 32'd1);
  endtask

  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    proc0 = 32'h09; proc3 = 32'h09;
    if0.req_valid = 1'b0; if0.req_shape = KEEP_SHAPE; if0.req_operation = KEEP_OPERATION; if0.rsp_ready = 1'b0;
    if3.req_valid = 1'b0; if3.req_shape = KEEP_SHAPE; if3.req_operation = KEEP_OPERATION; if3.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst0/req_ready", 32'(if0.req_ready), 32'd0);
    chk("rst0/rsp_valid", 32'(if0.rsp_valid), 32'd0);
    chk("rst0/rsp_status", 32'(if0.rsp_status), 32'd0);
    chk("rst0/rsp_shape", 32'(if0.rsp_shape), 32'd0);
    chk("rst0/rsp_op", 32'(if0.rsp_operation), 32'd0);
    chk("rst0/write", 32'(if0.write), 32'd0);
    chk("rst0/read", 32'(if0.read), 32'd0);
    chk("rst0/write_data", if0.write_data, 32'd0);
    chk("rst3/req_ready", 32'(if3.req_ready), 32'd0);
    chk("rst3/read", 32'(if3.read), 32'd0);

    rst0 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    chk("init0/read_c1", 32'(if0.read), 32'd1);
    chk("init0/ready_c1", 32'(if0.req_ready), 32'd0);
    chk("init3/read_c1", 32'(if3.read), 32'd1);
    @(negedge clk);
    chk("init0/read_c2", 32'(if0.read), 32'd0);
    chk("init0/ready_c2", 32'(if0.req_ready), 32'd1);
    chk("init3/read_c2", 32'(if3.read), 32'd0);
    chk("init3/ready_c2", 32'(if3.req_ready), 32'd0);
    for (int c = 3; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("init3/ready_c%0d", c), 32'(if3.req_ready), 32'(c == 5));
    end

    // Latency 0: shadow {CIRCLE,AREA} after init.
    req0("keep_init", KEEP_SHAPE, KEEP_OPERATION, 32'h00, 32'h09, 2'd0, CIRCLE, AREA);
    req0("tri_iso", TRIANGLE, IS_ISOSCELES, 32'h2B, 32'h2B, 2'd0, TRIANGLE, IS_ISOSCELES);
    req0("rect_area", RECTANGLE, AREA, 32'h0A, 32'h0A, 2'd0, RECTANGLE, AREA);
    req0("keep_square", KEEP_SHAPE, IS_SQUARE, 32'h18, 32'h1A, 2'd0, RECTANGLE, IS_SQUARE);
`ifdef SHAPE_PROCESSOR_CTRL_DRIVER_PRECHECK_EN
    req0("keep_equi", KEEP_SHAPE, IS_EQUILATERAL, 32'h20, 32'h1A, 2'd3, RECTANGLE, IS_SQUARE);
    req0("rsv_same", shape_e'(3'd6), AREA, 32'h0E, 32'h1A, 2'd3, RECTANGLE, IS_SQUARE);
    req0("rsv_alter", shape_e'(3'd6), AREA, 32'h0E, 32'h11, 2'd3, RECTANGLE, IS_SQUARE);
    req0("shadow_chk", KEEP_SHAPE, KEEP_OPERATION, 32'h00, 32'h1A, 2'd0, RECTANGLE, IS_SQUARE);
`else
    req0("keep_equi", KEEP_SHAPE, IS_EQUILATERAL, 32'h20, 32'h1A, 2'd1, RECTANGLE, IS_SQUARE);
    req0("rsv_same", shape_e'(3'd6), AREA, 32'h0E, 32'h1A, 2'd1, RECTANGLE, IS_SQUARE);
    req0("rsv_alter", shape_e'(3'd6), AREA, 32'h0E, 32'h11, 2'd2, CIRCLE, PERIMETER);
    req0("shadow_chk", KEEP_SHAPE, KEEP_OPERATION, 32'h00, 32'h11, 2'd0, CIRCLE, PERIMETER);
`endif

    // Reset while write is high.
    if0.req_valid = 1'b1; if0.req_shape = CIRCLE; if0.req_operation = AREA;
    @(negedge clk);
    if0.req_valid = 1'b0;
    chk("midrst/write_pre", 32'(if0.write), 32'd1);
    rst0 = 1'b1;
    @(negedge clk);
    chk("midrst/write", 32'(if0.write), 32'd0);
    chk("midrst/read", 32'(if0.read), 32'd0);
    chk("midrst/rsp_valid", 32'(if0.rsp_valid), 32'd0);
    chk("midrst/req_ready", 32'(if0.req_ready), 32'd0);
    chk("midrst/write_data", if0.write_data, 32'd0);
    rst0 = 1'b0;
    proc0 = 32'h2B;
    @(negedge clk);
    chk("midrst/init_read", 32'(if0.read), 32'd1);
    chk("midrst/rsp_valid_c1", 32'(if0.rsp_valid), 32'd0);
    @(negedge clk);
    chk("midrst/ready_c2", 32'(if0.req_ready), 32'd1);
    chk("midrst/rsp_valid_c2", 32'(if0.rsp_valid), 32'd0);
    req0("midrst_shadow", KEEP_SHAPE, KEEP_OPERATION, 32'h00, 32'h2B, 2'd0, TRIANGLE, IS_ISOSCELES);

    // Latency 3 with early rsp_ready and a stalled consumer.
    chk("lat3/req_ready", 32'(if3.req_ready), 32'd1);
    if3.req_valid = 1'b1; if3.req_shape = CIRCLE; if3.req_operation = PERIMETER;
    @(negedge clk);
    if3.req_valid = 1'b0;
    chk("lat3/write", 32'(if3.write), 32'd1);
    chk("lat3/write_data", if3.write_data, 32'h11);
    proc3 = 32'h11;
    if3.rsp_ready = 1'b1;
    @(negedge clk);
    chk("lat3/write_drop", 32'(if3.write), 32'd0);
    chk("lat3/read", 32'(if3.read), 32'd1);
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("lat3/no_rsp_t%0d", k), 32'(if3.rsp_valid), 32'd0);
      chk($sformatf("lat3/read_t%0d", k), 32'(if3.read), 32'd0);
    end
    if3.rsp_ready = 1'b0;
    for (int k = 6; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("lat3/rsp_valid_t%0d", k), 32'(if3.rsp_valid), 32'd1);
      chk($sformatf("lat3/status_t%0d", k), 32'(if3.rsp_status), 32'd0);
      chk($sformatf("lat3/shape_t%0d", k), 32'(if3.rsp_shape), 32'(CIRCLE));
      chk($sformatf("lat3/op_t%0d", k), 32'(if3.rsp_operation), 32'(PERIMETER));
      chk($sformatf("lat3/busy_t%0d", k), 32'(if3.req_ready), 32'd0);
    end
    if3.rsp_ready = 1'b1;
    @(negedge clk);
    if3.rsp_ready = 1'b0;
    chk("lat3/rsp_drop", 32'(if3.rsp_valid), 32'd0);
    chk("lat3/ready_back", 32'(if3.req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
